reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of 2, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (>=1).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rd_num  input  NREAD*AW  packed read indices; port k at bits [k*AW +: AW].
REQ-007 SHALL have port rd_res  output  NREAD*XLEN  packed read data, port k at [k*XLEN +: XLEN].
REQ-008 SHALL have port rd_busy  output  NREAD  per-port "value pending" flag.
REQ-009 SHALL have ports wr0_en / wr1_en  input  1 each  write enables (wr0 = ALU writeback, wr1 = load writeback).
REQ-010 SHALL have ports wr0_num / wr1_num  input  AW each  write indices.
REQ-011 SHALL have ports wr0_res / wr1_res  input  XLEN each  write data.
REQ-012 SHALL have ports rsv_en  input  1 and rsv_num  input  AW: reserve destination at issue.
REQ-013 SHALL have port flush  input  1  synchronous clear of all busy bits.
REQ-014 SHALL have port any_busy  output  1  OR of all busy bits.

Function
REQ-015 SHALL hold registers 1..NREGS-1 as flops; register 0 SHALL read 0, never be written, never be busy.
REQ-016 Write: on clk edge with wrX_en=1 and wrX_num!=0, reg[wrX_num] <= wrX_res.
REQ-017 Both ports writing same nonzero index same cycle: wr1 SHALL win; wr0 data discarded.
REQ-018 Read: combinational, zero latency; rd_res[k] = 0 if rd_num[k]==0.
REQ-019 Bypass: if a same-cycle enabled write targets rd_num[k] (nonzero), rd_res[k] SHALL return that write data (wr1 over wr0), else stored value.
REQ-020 Busy bits: one per register, 1..NREGS-1.
REQ-021 rsv_en=1, rsv_num!=0 -> busy[rsv_num] <= 1 at edge.
REQ-022 Enabled write to nonzero n -> busy[n] <= 0 at edge, unless rsv_en targets n same cycle, then busy[n] <= 1 (reservation wins).
REQ-023 rsv_en or write with index 0: no state change.
REQ-024 flush=1 -> all busy <= 0 at edge, overriding same-cycle rsv_en; same-cycle writes still update data.
REQ-025 rd_busy[k] = busy[rd_num[k]] AND NOT(same-cycle enabled write to rd_num[k]); 0 for index 0.
REQ-026 any_busy reflects registered busy bits only (no same-cycle bypass).
REQ-027 Multiple read ports SHALL be fully independent; same index on all ports gives identical results.
REQ-028 Write to a register not busy SHALL be legal and update data; busy stays 0.

Reset
REQ-029 rst=0 SHALL asynchronously clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-030 While rst=0, writes, rsv_en and flush SHALL be ignored; rd_res SHALL read 0, rd_busy and any_busy 0.
REQ-031 Reset asserted mid-operation (pending reservations) SHALL discard them; first edge after rst rises SHALL process inputs normally.

Verification
REQ-032 Reset then read all indices on all ports -> rd_res=0, rd_busy=0, any_busy=0.
REQ-033 wr0 x5=0xDEADBEEF; next cycle rd_num[0]=5 -> 0xDEADBEEF; same-cycle write x6=0x12345678 with rd_num[1]=6 -> bypass 0x12345678.
REQ-034 wr0 x7=0x1, wr1 x7=0x2 same cycle -> x7 reads 0x2; wr0 x0=0xFFFFFFFF -> x0 reads 0.
REQ-035 rsv x3 -> rd_busy=1, any_busy=1; wr1 x3=0xAA -> that cycle rd_busy=0, rd_res=0xAA; next cycle busy 0; rsv x3 plus wr x3 same cycle -> busy stays 1.
REQ-036 rsv x4 and x9, assert flush with rsv x10 -> all busy 0, any_busy=0.
REQ-037 Pending x8 busy, data 0x55; drop rst between edges -> immediate rd_res=0, busy=0; release, wr x8=0x1 -> reads 0x1; repeat with NREAD=4, XLEN=64, NREGS=16.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb -- integer register file with a per-register scoreboard.
//
// Registers 1..NREGS-1 hold data; register 0 reads as zero, is never
// written and is never busy. Two write ports (wr0 = ALU writeback,
// wr1 = load writeback) commit on the rising clock edge; wr1 wins when
// both target the same register. Each of the NREAD read ports is purely
// combinational and bypasses same-cycle write data. A busy bit per
// register marks a value still in flight: it is set by a reservation at
// issue (rsv_en/rsv_num), cleared by a writeback and cleared globally by
// flush. rst is asynchronous and active-low.
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   rst              asynchronous active-low reset
//   rd_num[k*AW+:AW] read index of port k
//   rd_res[k*XLEN+:XLEN] read data of port k (bypassed)
//   rd_busy[k]       value of port k's register is still pending
//   wr0_en/num/res   ALU writeback port
//   wr1_en/num/res   load writeback port (higher priority)
//   rsv_en/rsv_num   mark destination register busy at issue
//   flush            clear every busy bit
//   any_busy         OR of the registered busy bits

module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_num,
    output logic [NREAD*XLEN-1:0] rd_res,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr0_en,
    input  logic [AW-1:0]         wr0_num,
    input  logic [XLEN-1:0]       wr0_res,
    input  logic                  wr1_en,
    input  logic [AW-1:0]         wr1_num,
    input  logic [XLEN-1:0]       wr1_res,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_num,
    input  logic                  flush,
    output logic                  any_busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr0_act;
    logic             wr1_act;
    logic             rsv_act;

    // Index 0 is the hard-wired zero register: writes and reservations
    // aimed at it are dropped here so nothing below needs to care.
    assign wr0_act = wr0_en && (wr0_num != '0);
    assign wr1_act = wr1_en && (wr1_num != '0);
    assign rsv_act = rsv_en && (rsv_num != '0);

    // Writebacks retire a pending value; a reservation issued in the same
    // cycle belongs to a younger instruction, so it is applied last and
    // wins. flush discards every outstanding reservation.
    always_comb begin
        busy_nxt = busy;
        if (wr0_act) busy_nxt[wr0_num] = 1'b0;
        if (wr1_act) busy_nxt[wr1_num] = 1'b0;
        if (rsv_act) busy_nxt[rsv_num] = 1'b1;
        if (flush)   busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    // wr1 is assigned after wr0 so it takes the register on a collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (wr0_act) regs[wr0_num] <= wr0_res;
            if (wr1_act) regs[wr1_num] <= wr1_res;
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign idx = rd_num[k*AW +: AW];

        // A value arriving this cycle is forwarded and is no longer
        // pending. Reset forces the outputs low so a bypassed write cannot
        // leak through while the array is held clear.
        always_comb begin
            data = regs[idx];
            bsy  = busy[idx];
            if (wr0_act && (wr0_num == idx)) begin
                data = wr0_res;
                bsy  = 1'b0;
            end
            if (wr1_act && (wr1_num == idx)) begin
                data = wr1_res;
                bsy  = 1'b0;
            end
            if (!rst || (idx == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rd_res[k*XLEN +: XLEN] = data;
        assign rd_busy[k]             = bsy;
    end

    // Registered bits only; same-cycle writebacks do not clear it early.
    assign any_busy = |busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb -- self-checking bench for reg_file_sb.
// Instance a uses the default geometry (32 x 32-bit, 2 read ports) and is
// checked against an array-based reference model; instance b uses
// NREAD=4, XLEN=64, NREGS=16 and is checked with directed expectations.

module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance a: defaults ----------------
    logic        a_rst;
    logic [9:0]  a_rd_num;
    logic [63:0] a_rd_res;
    logic [1:0]  a_rd_busy;
    logic        a_wr0_en, a_wr1_en, a_rsv_en, a_flush, a_any_busy;
    logic [4:0]  a_wr0_num, a_wr1_num, a_rsv_num;
    logic [31:0] a_wr0_res, a_wr1_res;

    reg_file_sb dut_a (
        .clk(clk), .rst(a_rst), .rd_num(a_rd_num), .rd_res(a_rd_res),
        .rd_busy(a_rd_busy), .wr0_en(a_wr0_en), .wr0_num(a_wr0_num),
        .wr0_res(a_wr0_res), .wr1_en(a_wr1_en), .wr1_num(a_wr1_num),
        .wr1_res(a_wr1_res), .rsv_en(a_rsv_en), .rsv_num(a_rsv_num),
        .flush(a_flush), .any_busy(a_any_busy)
    );

    // ---------------- instance b: wide geometry ----------------
    logic         b_rst;
    logic [15:0]  b_rd_num;
    logic [255:0] b_rd_res;
    logic [3:0]   b_rd_busy;
    logic         b_wr0_en, b_wr1_en, b_rsv_en, b_flush, b_any_busy;
    logic [3:0]   b_wr0_num, b_wr1_num, b_rsv_num;
    logic [63:0]  b_wr0_res, b_wr1_res;

    reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(4)) dut_b (
        .clk(clk), .rst(b_rst), .rd_num(b_rd_num), .rd_res(b_rd_res),
        .rd_busy(b_rd_busy), .wr0_en(b_wr0_en), .wr0_num(b_wr0_num),
        .wr0_res(b_wr0_res), .wr1_en(b_wr1_en), .wr1_num(b_wr1_num),
        .wr1_res(b_wr1_res), .rsv_en(b_rsv_en), .rsv_num(b_rsv_num),
        .flush(b_flush), .any_busy(b_any_busy)
    );

    // ---------------- reference model for instance a ----------------
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic bit writing(input int idx);
        return idx != 0 &&
               ((a_wr0_en && int'(a_wr0_num) == idx) ||
                (a_wr1_en && int'(a_wr1_num) == idx));
    endfunction

    function automatic logic [31:0] exp_data(input int idx);
        if (idx == 0) return 32'h0;
        if (a_wr1_en && int'(a_wr1_num) == idx) return a_wr1_res;
        if (a_wr0_en && int'(a_wr0_num) == idx) return a_wr0_res;
        return m_reg[idx];
    endfunction

    function automatic bit exp_busy(input int idx);
        return idx != 0 && m_busy[idx] && !writing(idx);
    endfunction

    function automatic bit exp_any();
        bit r = 1'b0;
        for (int i = 1; i < 32; i++) r = r | m_busy[i];
        return r;
    endfunction

    // Apply the architectural effect of the current inputs at the next edge.
    task automatic model_commit();
        int w0 = int'(a_wr0_num);
        int w1 = int'(a_wr1_num);
        int rv = int'(a_rsv_num);
        if (a_wr0_en && w0 != 0) begin m_reg[w0] = a_wr0_res; m_busy[w0] = 1'b0; end
        if (a_wr1_en && w1 != 0) begin m_reg[w1] = a_wr1_res; m_busy[w1] = 1'b0; end
        if (a_rsv_en && rv != 0) m_busy[rv] = 1'b1;
        if (a_flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_wr0_en = 0; a_wr0_num = 0; a_wr0_res = 0;
        a_wr1_en = 0; a_wr1_num = 0; a_wr1_res = 0;
        a_rsv_en = 0; a_rsv_num = 0; a_flush = 0;
    endtask

    task automatic clear_b();
        b_wr0_en = 0; b_wr0_num = 0; b_wr0_res = 0;
        b_wr1_en = 0; b_wr1_num = 0; b_wr1_res = 0;
        b_rsv_en = 0; b_rsv_num = 0; b_flush = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_a();
        a_wr0_en = 1; a_wr0_num = 5; a_wr0_res = 32'hFFFF_0000;
        for (int i = 0; i < 32; i += 7) begin
            a_rd_num = {i[4:0], 5'd5};
            #1;
            checks++;
            if ({a_rd_res, a_rd_busy, a_any_busy} !== '0) begin
                errors++;
                $display("FAIL in_reset idx %0d: res=%h busy=%b any=%b expected all zero",
                         i, a_rd_res, a_rd_busy, a_any_busy);
            end
        end
        clear_a();
        @(negedge clk);
        a_rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            a_rd_num = {i[4:0], i[4:0]};
            @(negedge clk);
            checks++;
            if ({a_rd_res, a_rd_busy, a_any_busy} !== '0) begin
                errors++;
                $display("FAIL after_reset idx %0d: res=%h busy=%b any=%b expected all zero",
                         i, a_rd_res, a_rd_busy, a_any_busy);
            end
            tick();
        end
    endtask

    task automatic test_write_bypass();
        clear_a();
        a_wr0_en = 1; a_wr0_num = 5; a_wr0_res = 32'hDEADBEEF;
        a_rd_num = {5'd0, 5'd5};
        @(negedge clk);
        tick();
        clear_a();
        a_wr0_en = 1; a_wr0_num = 6; a_wr0_res = 32'h12345678;
        a_rd_num = {5'd6, 5'd5};
        @(negedge clk);
        checks++;
        if (a_rd_res[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_x5: got %h expected deadbeef", a_rd_res[31:0]);
        end
        checks++;
        if (a_rd_res[63:32] !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_x6: got %h expected 12345678", a_rd_res[63:32]);
        end
        tick();
    endtask

    task automatic test_write_conflict();
        clear_a();
        a_wr0_en = 1; a_wr0_num = 7; a_wr0_res = 32'h1;
        a_wr1_en = 1; a_wr1_num = 7; a_wr1_res = 32'h2;
        a_rd_num = {5'd7, 5'd0};
        @(negedge clk);
        checks++;
        if (a_rd_res[63:32] !== 32'h2) begin
            errors++;
            $display("FAIL bypass_conflict_x7: got %h expected 2", a_rd_res[63:32]);
        end
        tick();
        clear_a();
        a_wr0_en = 1; a_wr0_num = 0; a_wr0_res = 32'hFFFFFFFF;
        a_rd_num = {5'd0, 5'd7};
        @(negedge clk);
        checks++;
        if (a_rd_res !== {32'h0, 32'h2}) begin
            errors++;
            $display("FAIL stored_x7_bypass_x0: got %h expected 00000000_00000002", a_rd_res);
        end
        tick();
        clear_a();
        a_rd_num = {5'd0, 5'd0};
        @(negedge clk);
        checks++;
        if (a_rd_res !== 64'h0 || a_rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL x0_after_write: res=%h busy=%b expected 0 and 00", a_rd_res, a_rd_busy);
        end
        tick();
    endtask

    task automatic test_reserve();
        clear_a();
        a_rsv_en = 1; a_rsv_num = 3;
        a_rd_num = {5'd3, 5'd3};
        @(negedge clk);
        checks++;
        if (a_rd_busy !== 2'b00 || a_any_busy !== 1'b0) begin
            errors++;
            $display("FAIL rsv_not_yet: busy=%b any=%b expected 00 0", a_rd_busy, a_any_busy);
        end
        tick();
        clear_a();
        @(negedge clk);
        checks++;
        if (a_rd_busy !== 2'b11 || a_any_busy !== 1'b1) begin
            errors++;
            $display("FAIL rsv_x3_busy: busy=%b any=%b expected 11 1", a_rd_busy, a_any_busy);
        end
        tick();
        clear_a();
        a_wr1_en = 1; a_wr1_num = 3; a_wr1_res = 32'hAA;
        @(negedge clk);
        checks++;
        if (a_rd_busy !== 2'b00 || a_rd_res[31:0] !== 32'hAA || a_any_busy !== 1'b1) begin
            errors++;
            $display("FAIL wb_x3_same_cycle: busy=%b res=%h any=%b expected 00 000000aa 1",
                     a_rd_busy, a_rd_res[31:0], a_any_busy);
        end
        tick();
        clear_a();
        @(negedge clk);
        checks++;
        if (a_rd_busy !== 2'b00 || a_any_busy !== 1'b0 || a_rd_res[63:32] !== 32'hAA) begin
            errors++;
            $display("FAIL wb_x3_after: busy=%b any=%b res=%h expected 00 0 000000aa",
                     a_rd_busy, a_any_busy, a_rd_res[63:32]);
        end
        tick();
        clear_a();
        a_rsv_en = 1; a_rsv_num = 3;
        a_wr0_en = 1; a_wr0_num = 3; a_wr0_res = 32'hBB;
        @(negedge clk);
        tick();
        clear_a();
        @(negedge clk);
        checks++;
        if (a_rd_busy !== 2'b11 || a_rd_res[31:0] !== 32'hBB) begin
            errors++;
            $display("FAIL rsv_beats_wb: busy=%b res=%h expected 11 000000bb",
                     a_rd_busy, a_rd_res[31:0]);
        end
        a_wr0_en = 1; a_wr0_num = 3; a_wr0_res = 32'hCC;
        tick();
    endtask

    task automatic test_flush();
        clear_a();
        a_rsv_en = 1; a_rsv_num = 4;
        @(negedge clk);
        tick();
        a_rsv_num = 9;
        @(negedge clk);
        tick();
        clear_a();
        a_rd_num = {5'd9, 5'd4};
        @(negedge clk);
        checks++;
        if (a_rd_busy !== 2'b11 || a_any_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush: busy=%b any=%b expected 11 1", a_rd_busy, a_any_busy);
        end
        a_flush = 1; a_rsv_en = 1; a_rsv_num = 10;
        a_wr0_en = 1; a_wr0_num = 11; a_wr0_res = 32'h77;
        tick();
        clear_a();
        a_rd_num = {5'd11, 5'd10};
        @(negedge clk);
        checks++;
        if (a_any_busy !== 1'b0 || a_rd_busy !== 2'b00 || a_rd_res[63:32] !== 32'h77) begin
            errors++;
            $display("FAIL flush: any=%b busy=%b x11=%h expected 0 00 00000077",
                     a_any_busy, a_rd_busy, a_rd_res[63:32]);
        end
        tick();
    endtask

    task automatic test_async_reset();
        clear_a();
        a_wr0_en = 1; a_wr0_num = 8; a_wr0_res = 32'h55;
        a_rsv_en = 1; a_rsv_num = 8;
        @(negedge clk);
        tick();
        clear_a();
        a_rd_num = {5'd8, 5'd8};
        @(negedge clk);
        checks++;
        if (a_rd_busy !== 2'b11 || a_rd_res !== {32'h55, 32'h55} || a_any_busy !== 1'b1) begin
            errors++;
            $display("FAIL pending_x8: busy=%b res=%h any=%b expected 11 55/55 1",
                     a_rd_busy, a_rd_res, a_any_busy);
        end
        #2;
        a_rst = 1'b0;
        #1;
        checks++;
        if ({a_rd_res, a_rd_busy, a_any_busy} !== '0) begin
            errors++;
            $display("FAIL async_reset_immediate: res=%h busy=%b any=%b expected all zero",
                     a_rd_res, a_rd_busy, a_any_busy);
        end
        a_wr0_en = 1; a_wr0_num = 9; a_wr0_res = 32'h99;
        a_rsv_en = 1; a_rsv_num = 9;
        @(posedge clk);
        #1;
        @(negedge clk);
        a_rst = 1'b1;
        clear_a();
        model_reset();
        a_rd_num = {5'd9, 5'd8};
        #1;
        checks++;
        if ({a_rd_res, a_rd_busy, a_any_busy} !== '0) begin
            errors++;
            $display("FAIL ignored_in_reset: res=%h busy=%b any=%b expected all zero",
                     a_rd_res, a_rd_busy, a_any_busy);
        end
        a_wr0_en = 1; a_wr0_num = 8; a_wr0_res = 32'h1;
        tick();
        clear_a();
        a_rd_num = {5'd8, 5'd8};
        @(negedge clk);
        checks++;
        if (a_rd_res !== {32'h1, 32'h1} || a_rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL first_edge_after_reset: res=%h busy=%b expected 1/1 00",
                     a_rd_res, a_rd_busy);
        end
        tick();
    endtask

    function automatic logic [4:0] rand_idx();
        if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            a_rd_num  = {rand_idx(), rand_idx()};
            a_wr0_en  = 1'($urandom_range(0, 1));
            a_wr0_num = rand_idx();
            a_wr0_res = $urandom;
            a_wr1_en  = ($urandom_range(0, 2) == 0);
            a_wr1_num = rand_idx();
            a_wr1_res = $urandom;
            a_rsv_en  = 1'($urandom_range(0, 1));
            a_rsv_num = rand_idx();
            a_flush   = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int idx = int'(a_rd_num[k*5 +: 5]);
                checks++;
                if (a_rd_res[k*32 +: 32] !== exp_data(idx)) begin
                    errors++;
                    $display("FAIL rand_data c%0d port%0d idx%0d: got %h expected %h",
                             c, k, idx, a_rd_res[k*32 +: 32], exp_data(idx));
                end
                checks++;
                if (a_rd_busy[k] !== exp_busy(idx)) begin
                    errors++;
                    $display("FAIL rand_busy c%0d port%0d idx%0d: got %b expected %b",
                             c, k, idx, a_rd_busy[k], exp_busy(idx));
                end
            end
            checks++;
            if (a_any_busy !== exp_any()) begin
                errors++;
                $display("FAIL rand_any c%0d: got %b expected %b", c, a_any_busy, exp_any());
            end
            tick();
        end
        clear_a();
    endtask

    task automatic test_wide();
        clear_b();
        b_rd_num = {4{4'd8}};
        #1;
        checks++;
        if ({b_rd_res, b_rd_busy, b_any_busy} !== '0) begin
            errors++;
            $display("FAIL wide_in_reset: busy=%b any=%b expected zero", b_rd_busy, b_any_busy);
        end
        @(negedge clk);
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            b_rd_num = {4{i[3:0]}};
            @(negedge clk);
            checks++;
            if ({b_rd_res, b_rd_busy, b_any_busy} !== '0) begin
                errors++;
                $display("FAIL wide_after_reset idx %0d: busy=%b any=%b expected zero",
                         i, b_rd_busy, b_any_busy);
            end
            @(posedge clk);
            #1;
        end
        b_wr0_en = 1; b_wr0_num = 8; b_wr0_res = 64'h55;
        b_rsv_en = 1; b_rsv_num = 8;
        @(posedge clk);
        #1;
        clear_b();
        b_rd_num = {4'd0, 4'd8, 4'd3, 4'd8};
        b_wr1_en = 1; b_wr1_num = 3; b_wr1_res = 64'hCAFE_F00D_1234_5678;
        @(negedge clk);
        checks++;
        if (b_rd_res !== {64'h0, 64'h55, 64'hCAFE_F00D_1234_5678, 64'h55} ||
            b_rd_busy !== 4'b0101 || b_any_busy !== 1'b1) begin
            errors++;
            $display("FAIL wide_ports: res=%h busy=%b any=%b expected 0/55/cafef00d12345678/55 0101 1",
                     b_rd_res, b_rd_busy, b_any_busy);
        end
        @(posedge clk);
        #2;
        clear_b();
        b_rst = 1'b0;
        #1;
        checks++;
        if ({b_rd_res, b_rd_busy, b_any_busy} !== '0) begin
            errors++;
            $display("FAIL wide_async_reset: busy=%b any=%b expected zero", b_rd_busy, b_any_busy);
        end
        @(negedge clk);
        b_rst = 1'b1;
        b_wr1_en = 1; b_wr1_num = 8; b_wr1_res = 64'h1;
        @(posedge clk);
        #1;
        clear_b();
        @(negedge clk);
        checks++;
        if (b_rd_res !== {64'h0, 64'h1, 64'h0, 64'h1} || b_rd_busy !== 4'b0000 ||
            b_any_busy !== 1'b0) begin
            errors++;
            $display("FAIL wide_after_release: res=%h busy=%b any=%b expected 0/1/0/1 0000 0",
                     b_rd_res, b_rd_busy, b_any_busy);
        end
    endtask

    initial begin
        a_rst = 1'b0;
        b_rst = 1'b0;
        a_rd_num = '0;
        b_rd_num = '0;
        clear_a();
        clear_b();
        model_reset();
        #2;
        test_reset();
        test_write_bypass();
        test_write_conflict();
        test_reserve();
        test_flush();
        test_async_reset();
        test_random();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
